dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the core's data-memory port. Replaces the fixed-latency data_ram
//  with a handshaked request/response SRAM model that has programmable wait states.
//  Raises a stall request to the pipeline stall controller while an access is outstanding.
//  Sits between the MEM stage request and the mem/mem_wb load path.
// PARAMETERS
//  ADDR_W       10  word-address bits; storage = 2**ADDR_W x 32-bit words
//  WAIT_CYCLES  2   extra cycles between acceptance and response (0..15)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  reset      in   1   synchronous, active-low reset
//  req        in   1   access request from MEM stage; held with fields until accepted
//  wr_strb    in   4   byte write strobes; 4'b0000 = load; bit i -> wdata[8i+7:8i]
//  addr       in   32  byte address; word index = addr[ADDR_W+1:2]
//  wdata      in   32  store data, byte lanes little-endian
//  addr_ok    out  1   request accepted this cycle when req && addr_ok
//  data_ok    out  1   one-cycle response pulse; rdata valid this cycle
//  rdata      out  32  load data (full word; lane selection done by mem)
//  stall_req  out  1   high while an accepted or pending access is not yet answered
// BEHAVIOUR
//  - States: IDLE, WAIT, RESP. Reset -> IDLE, data_ok=0, rdata=0, wait counter=0,
//    latched request fields=0. Storage array is not cleared by reset.
//  - addr_ok = (state==IDLE), combinational. No acceptance in WAIT or RESP.
//  - IDLE: on req&&addr_ok latch addr word index, wr_strb, wdata; load counter with
//    WAIT_CYCLES; go WAIT if WAIT_CYCLES>0, else RESP.
//  - WAIT: decrement counter each cycle; when counter reaches 1 -> RESP next cycle.
//  - RESP: data_ok=1 for exactly this cycle, then IDLE. Load: rdata = mem[idx].
//    Store: byte lanes with strobe set written at end of RESP cycle; rdata = 0.
//  - Latency: accepted at cycle T -> data_ok at T+1+WAIT_CYCLES. Max throughput one
//    access per WAIT_CYCLES+2 cycles; a req held through RESP is accepted the cycle after.
//  - rdata holds last value outside RESP except it is driven 0 on store responses.
//  - stall_req = (req && state==IDLE) || (state==WAIT) || (state==RESP && !data_ok);
//    i.e. deasserts in the data_ok cycle so the pipeline advances with the result.
//  - Addresses: addr[1:0] ignored for indexing; bits above ADDR_W+1 ignored (aliasing).
//  - Reset mid-operation: transaction dropped; no store is performed, no data_ok issued.
//  - Input changes after acceptance have no effect on the in-flight access.
// TESTING
//  1 reset low 2 cycles -> data_ok=0, rdata=0, addr_ok=1, stall_req=0 (req=0).
//  2 WAIT=2: store 0xDEADBEEF strb 4'hF addr 0x10 accepted T -> data_ok only at T+3,
//    stall_req high T..T+2; then load 0x10 -> rdata 0xDEADBEEF with data_ok.
//  3 store strb 4'b0010 wdata 0x0000AA00 addr 0x10 -> load 0x10 returns 0xDEADAAEF.
//  4 req held high for 3 back-to-back loads -> addr_ok low in WAIT/RESP; acceptances
//    spaced exactly 4 cycles apart (WAIT=2); one data_ok per load.
//  5 store 0x12345678 to 0x20 (old 0x0BADF00D), reset low during WAIT -> no data_ok;
//    after reset, load 0x20 returns 0x0BADF00D.
//  6 WAIT_CYCLES=0, ADDR_W=10: load 0x10 + 0x1000 -> data_ok at T+1, rdata = word at 0x10.

Source files
------------

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: SRAM model with programmable wait states,
// one outstanding access at a time, and a stall request toward the pipeline.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  wr_strb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        stall_req
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t              state;
    logic [3:0]          wait_cnt;
    logic [ADDR_W-1:0]   idx_q;
    logic [3:0]          strb_q;
    logic [31:0]         wdata_q;
    logic [ADDR_W-1:0]   req_idx;
    logic [31:0]         mem [2**ADDR_W];

    // Byte offset and high address bits do not select storage; high bits alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign req_idx   = addr[ADDR_W+1:2];
    assign addr_ok   = (state == IDLE);
    assign stall_req = (req && state == IDLE) || (state == WAIT) || (state == RESP && !data_ok);

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            data_ok  <= 1'b0;
            rdata    <= '0;
            wait_cnt <= '0;
            idx_q    <= '0;
            strb_q   <= '0;
            wdata_q  <= '0;
        end else begin
            data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q    <= req_idx;
                        strb_q   <= wr_strb;
                        wdata_q  <= wdata;
                        wait_cnt <= WAIT_INIT;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                        end else begin
                            state   <= RESP;
                            data_ok <= 1'b1;
                            rdata   <= (wr_strb == 4'b0000) ? mem[req_idx] : 32'h0;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    // Response data is captured on entry so it is valid during RESP.
                    if (wait_cnt == 4'd1) begin
                        state   <= RESP;
                        data_ok <= 1'b1;
                        rdata   <= (strb_q == 4'b0000) ? mem[idx_q] : 32'h0;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; only the write enable
    // is gated by reset so a transaction caught by reset never commits.
    always_ff @(posedge clk) begin
        if (reset && state == RESP) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios plus randomized traffic
// checked against an associative-array memory model with latency bookkeeping.
module tb_dmem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [3:0]  wr_strb = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        addr_ok, data_ok, stall_req;
    logic [31:0] rdata;

    logic        req0 = 1'b0;
    logic [3:0]  wr_strb0 = '0;
    logic [31:0] addr0 = '0;
    logic [31:0] wdata0 = '0;
    logic        addr_ok0, data_ok0, stall_req0;
    logic [31:0] rdata0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req(req), .wr_strb(wr_strb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .stall_req(stall_req)
    );

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .wr_strb(wr_strb0), .addr(addr0), .wdata(wdata0),
        .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0), .stall_req(stall_req0)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_accept = 0;
    exp_t        sb[$];
    logic [31:0] model_mem [int];
    logic [31:0] last_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory semantics: loads return the stored word, stores merge strobed bytes and answer 0.
    function automatic logic [31:0] model_access(input logic [3:0] s, input logic [31:0] a,
                                                 input logic [31:0] d);
        int          idx;
        logic [31:0] word;
        idx  = int'((a / 4) % 1024);
        word = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        if (s == 4'b0000) return word;
        for (int b = 0; b < 4; b++)
            if (s[b]) word[8*b +: 8] = d[8*b +: 8];
        model_mem[idx] = word;
        return 32'h0;
    endfunction

    // Monitor: every negedge, compare handshake outputs and pop the due response.
    always @(negedge clk) begin : monitor
        bit busy;
        if (!reset) begin
            sb.delete();
            last_rdata = '0;
        end else begin
            busy = (sb.size() != 0);
            check("addr_ok", 32'(addr_ok), 32'(!busy));
            check("stall_req", 32'(stall_req), busy ? 32'(cyc != sb[0].due) : 32'(req));
            if (busy && cyc >= sb[0].due) begin
                check("data_ok", 32'(data_ok), 32'd1);
                check("rdata", rdata, sb[0].data);
                last_rdata = sb[0].data;
                void'(sb.pop_front());
            end else begin
                check("no_data_ok", 32'(data_ok), 32'd0);
                check("rdata_hold", rdata, last_rdata);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic access(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                          input bit hold);
        bit   done;
        exp_t e;
        done    = 1'b0;
        req     = 1'b1;
        wr_strb = s;
        addr    = a;
        wdata   = d;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk); #1;
            if (addr_ok) begin
                e.data = model_access(s, a, d);
                e.due  = cyc + 1 + W;
                sb.push_back(e);
                last_accept = cyc;
                done = 1'b1;
                @(posedge clk); #1;
                if (!hold) req = 1'b0;
            end
        end
        if (!done) begin
            check("accept_timeout", 32'd0, 32'd1);
            req = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int a0, a1, a2;
        logic [31:0] ra;
        logic [3:0]  rs;
        bit          rh;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_ok", 32'(data_ok), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_addr_ok", 32'(addr_ok), 32'd1);
        check("rst_stall_req", 32'(stall_req), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Full store then load
        access(4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
        access(4'h0, 32'h10, 32'h0, 1'b0);
        drain();

        // Single-lane store merge
        access(4'b0010, 32'h10, 32'h0000AA00, 1'b0);
        access(4'h0, 32'h10, 32'h0, 1'b0);
        drain();

        // Back-to-back loads with req held
        access(4'h0, 32'h10, 32'h0, 1'b1);
        a0 = last_accept;
        access(4'h0, 32'h10, 32'h0, 1'b1);
        a1 = last_accept;
        access(4'h0, 32'h10, 32'h0, 1'b0);
        a2 = last_accept;
        check("b2b_spacing_1", 32'(a1 - a0), 32'(W + 2));
        check("b2b_spacing_2", 32'(a2 - a1), 32'(W + 2));
        drain();

        // Reset during WAIT drops the store
        access(4'hF, 32'h20, 32'h0BADF00D, 1'b0);
        drain();
        access(4'hF, 32'h20, 32'h12345678, 1'b0);
        reset = 1'b0;
        model_mem[8] = 32'h0BADF00D;  // the in-flight store never commits
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        access(4'h0, 32'h20, 32'h0, 1'b0);
        drain();

        // Randomized traffic over 16 initialized words with address aliasing
        for (int k = 0; k < 16; k++)
            access(4'hF, 32'h100 + 32'(4 * k), $urandom, 1'b0);
        for (int i = 0; i < 150; i++) begin
            ra = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3))
               + (32'($urandom_range(0, 15)) << 12);
            rs = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            rh = (i < 149) && ($urandom_range(0, 3) == 0);
            access(rs, ra, $urandom, rh);
            if (!rh) repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        drain();

        // Zero wait states: response the cycle after acceptance, aliased address
        req0 = 1'b1; wr_strb0 = 4'hF; addr0 = 32'h10; wdata0 = 32'hCAFEF00D;
        @(negedge clk); #1;
        check("w0_store_addr_ok", 32'(addr_ok0), 32'd1);
        check("w0_store_stall", 32'(stall_req0), 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk); #1;
        check("w0_store_data_ok", 32'(data_ok0), 32'd1);
        check("w0_store_rdata", rdata0, 32'h0);
        check("w0_store_stall_done", 32'(stall_req0), 32'd0);
        @(posedge clk); #1;
        req0 = 1'b1; wr_strb0 = 4'h0; addr0 = 32'h1010; wdata0 = 32'h0;
        @(negedge clk); #1;
        check("w0_load_addr_ok", 32'(addr_ok0), 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk); #1;
        check("w0_load_data_ok", 32'(data_ok0), 32'd1);
        check("w0_load_rdata", rdata0, 32'hCAFEF00D);
        @(negedge clk); #1;
        check("w0_after_data_ok", 32'(data_ok0), 32'd0);
        check("w0_rdata_hold", rdata0, 32'hCAFEF00D);

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
